// File: rtl/pll_seq_pkg.sv
// Shared state encodings and counter sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    typedef enum logic [2:0] {
        RESET_PLL = ST_RESET_PLL,
        WAIT_LOCK = ST_WAIT_LOCK,
        SETTLE    = ST_SETTLE,
        RUN       = ST_RUN,
        FAULT     = ST_FAULT
    } pll_state_e;

    function automatic int timer_width(input int reset_cycles, input int lock_timeout,
                                       input int settle_cycles);
        int m;
        m = reset_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (settle_cycles > m) m = settle_cycles;
        return $clog2(m + 1);
    endfunction

    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, clears to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the reference clock: reset pulse, lock wait, settle, run, fault.
//  state     | meaning
//  RESET_PLL | PLL RESETB held low for RESET_CYCLES
//  WAIT_LOCK | waiting for synchronised lock, bounded by LOCK_TIMEOUT
//  SETTLE    | lock must stay high continuously
//  RUN       | domain released; lock dips filtered by glitch counter
//  FAULT     | sticky after too many lock timeouts
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int SETTLE_CYCLES = 2400,
    parameter int GLITCH_CYCLES = 3,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             restart,
    output logic             pll_resetb,
    output logic             domain_reset_n,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int TIMER_W  = timer_width(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam int RETRY_W  = count_width(MAX_RETRIES);
    localparam int GLITCH_W = count_width(GLITCH_CYCLES);

    localparam logic [TIMER_W-1:0]  RESET_LAST  = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that saw lock counts as the first settle high.
    localparam logic [TIMER_W-1:0]  SETTLE_LAST = TIMER_W'((SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0);
    localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_state_e          r_state;
    pll_state_e          w_state_next;
    logic [TIMER_W-1:0]  r_timer;
    logic [RETRY_W-1:0]  r_retries;
    logic [GLITCH_W-1:0] r_glitch;
    logic [CNT_W-1:0]    r_loss_count;
    logic                r_pll_resetb;
    logic                r_domain_reset_n;
    logic                r_ready;
    logic                r_fault;
    logic                w_locked_s;
    logic                w_timer_clr;
    logic                w_retry_inc;
    logic                w_retry_clr;
    logic                w_loss_inc;

    sync_2ff u_sync_locked (
        .i_clk   (clock_in),
        .i_rst_n (reset_n),
        .i_d     (locked),
        .o_q     (w_locked_s)
    );

    always_comb begin
        w_state_next = r_state;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_loss_inc   = 1'b0;
        if (restart) begin
            w_state_next = RESET_PLL;
            w_retry_clr  = 1'b1;
        end else begin
            case (r_state)
                RESET_PLL: if (r_timer == RESET_LAST) w_state_next = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_next = SETTLE;
                    end else if (r_timer == LOCK_LAST) begin
                        if (r_retries < RETRY_MAX) begin
                            w_retry_inc  = 1'b1;
                            w_state_next = RESET_PLL;
                        end else begin
                            w_state_next = FAULT;
                        end
                    end
                end
                SETTLE: begin
                    if (!w_locked_s) begin
                        w_state_next = WAIT_LOCK;
                    end else if (r_timer == SETTLE_LAST) begin
                        w_state_next = RUN;
                        w_retry_clr  = 1'b1;
                    end
                end
                RUN: begin
                    if (!w_locked_s && (r_glitch == GLITCH_LAST)) begin
                        w_state_next = RESET_PLL;
                        w_loss_inc   = 1'b1;
                    end
                end
                FAULT:   w_state_next = FAULT;
                default: w_state_next = RESET_PLL;
            endcase
        end
        w_timer_clr = restart || (w_state_next != r_state);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= RESET_PLL;
            r_pll_resetb     <= 1'b0;
            r_domain_reset_n <= 1'b0;
            r_ready          <= 1'b0;
            r_fault          <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_pll_resetb     <= (w_state_next != RESET_PLL);
            r_domain_reset_n <= (w_state_next == RUN);
            r_ready          <= (w_state_next == RUN);
            r_fault          <= (w_state_next == FAULT);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_timer      <= '0;
            r_retries    <= '0;
            r_glitch     <= '0;
            r_loss_count <= '0;
        end else begin
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (r_state inside {RESET_PLL, WAIT_LOCK, SETTLE}) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_retry_clr) begin
                r_retries <= '0;
            end else if (w_retry_inc) begin
                r_retries <= r_retries + 1'b1;
            end

            if (w_timer_clr || w_locked_s) begin
                r_glitch <= '0;
            end else if (r_state == RUN) begin
                r_glitch <= r_glitch + 1'b1;
            end

            if (w_loss_inc && (r_loss_count != '1)) begin
                r_loss_count <= r_loss_count + 1'b1;
            end
        end
    end

    assign pll_resetb      = r_pll_resetb;
    assign domain_reset_n  = r_domain_reset_n;
    assign ready           = r_ready;
    assign fault           = r_fault;
    assign state           = r_state;
    assign lock_loss_count = r_loss_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timers; expected values worked out by hand.
module tb_pll_lock_sequencer;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       locked;
    logic       restart;
    logic       pll_resetb;
    logic       domain_reset_n;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (8),
        .GLITCH_CYCLES (2),
        .MAX_RETRIES   (2),
        .CNT_W         (8)
    ) dut (
        .clock_in        (clock_in),
        .reset_n         (reset_n),
        .locked          (locked),
        .restart         (restart),
        .pll_resetb      (pll_resetb),
        .domain_reset_n  (domain_reset_n),
        .ready           (ready),
        .fault           (fault),
        .state           (state),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, state, s);
    endtask

    // Pulses restart, then records PLL reset pulses until fault rises.
    task automatic restart_and_measure(output int pulses, output int start1, output int start2,
                                       output int lows, output int fault_at);
        logic prev;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        prev = 1'b1;
        pulses = 0; start1 = 0; start2 = 0; lows = 0; fault_at = 0;
        for (int k = 1; k <= 120 && fault_at == 0; k++) begin
            if (k > 1) tick();
            if (!pll_resetb) lows++;
            if (prev && !pll_resetb) begin
                pulses++;
                if (pulses == 1) start1 = k;
                if (pulses == 2) start2 = k;
            end
            prev = pll_resetb;
            if (fault) fault_at = k;
        end
    endtask

    task automatic check_fault_run(input string tag);
        int p, s1, s2, lo, fa;
        restart_and_measure(p, s1, s2, lo, fa);
        chk({tag, "_pulses"}, p, 3);
        chk({tag, "_first_pulse"}, s1, 1);
        chk({tag, "_second_pulse"}, s2, 25);
        chk({tag, "_low_cycles"}, lo, 12);
        chk({tag, "_fault_cycle"}, fa, 73);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_pll_resetb", pll_resetb, 0);
        chk("rst_domain", domain_reset_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_count", lock_loss_count, 0);

        // Normal bring-up
        reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!pll_resetb && n < 50);
        chk("resetb_low_cycles", n, 4);
        repeat (5) tick();
        chk("wait_lock_state", state, 1);
        locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ready && n < 40);
        chk("ready_latency", n, 10);
        chk("run_state", state, 3);
        chk("run_domain", domain_reset_n, 1);
        chk("run_fault", fault, 0);

        // One-cycle dip is filtered
        locked = 1'b0;
        tick();
        locked = 1'b1;
        repeat (6) tick();
        chk("dip1_state", state, 3);
        chk("dip1_ready", ready, 1);
        chk("dip1_count", lock_loss_count, 0);

        // Two-cycle dip is a loss
        locked = 1'b0;
        tick();
        tick();
        locked = 1'b1;
        wait_state("dip2_state", 3'd0, 10);
        chk("dip2_domain", domain_reset_n, 0);
        chk("dip2_ready", ready, 0);
        chk("dip2_pll_resetb", pll_resetb, 0);
        chk("dip2_count", lock_loss_count, 1);
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        chk("relock_ready", ready, 1);
        chk("relock_count", lock_loss_count, 1);

        // Restart from RUN, then drop lock during SETTLE
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_run_state", state, 0);
        chk("restart_run_domain", domain_reset_n, 0);
        chk("restart_run_count", lock_loss_count, 1);
        wait_state("reach_settle", 3'd2, 20);
        repeat (3) tick();
        locked = 1'b0;
        n = 0;
        while (state == 3'd2 && n < 10) begin tick(); n++; end
        chk("settle_drop_state", state, 1);
        chk("settle_drop_cycles", n, 3);
        chk("settle_drop_resetb", pll_resetb, 1);
        locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ready && n < 40);
        chk("fresh_settle_latency", n, 10);

        // Lock never rises: three attempts then FAULT
        locked = 1'b0;
        check_fault_run("nolock");
        chk("fault_state", state, 4);
        chk("fault_resetb", pll_resetb, 1);
        chk("fault_domain", domain_reset_n, 0);
        chk("fault_ready", ready, 0);
        chk("fault_count", lock_loss_count, 1);
        repeat (5) tick();
        chk("fault_sticky", fault, 1);

        // Restart out of FAULT, then restart colliding with a timeout
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_fault_state", state, 0);
        chk("restart_fault_flag", fault, 0);
        chk("restart_fault_resetb", pll_resetb, 0);
        chk("restart_fault_count", lock_loss_count, 1);
        repeat (23) tick();
        chk("pre_timeout_state", state, 1);
        check_fault_run("collide");

        // Async reset while in SETTLE
        locked = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wait_state("reach_settle2", 3'd2, 20);
        tick();
        tick();
        chk("settle2_state", state, 2);
        reset_n = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_resetb", pll_resetb, 0);
        chk("async_domain", domain_reset_n, 0);
        chk("async_ready", ready, 0);
        chk("async_fault", fault, 0);
        chk("async_count", lock_loss_count, 0);
        tick();
        reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!pll_resetb && n < 50);
        chk("rereset_low_cycles", n, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
